// File: rtl/ask_pkg.sv
// rtl/ask_pkg.sv - shared 4-ASK PWM definitions: FSM states, timing defaults, symbol duty table.
package ask_pkg;

    localparam int SYM_CYCLES_DEFAULT = 62500;
    localparam int TOL_CYCLES_DEFAULT = 625;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_GAP     = 2'd2
    } state_t;

    // Symbol n is high for (2n+1)/8 of the symbol period; the modulator uses the same table.
    function automatic int sym_high_cycles(input int n, input int sym_cycles);
        return ((2 * n + 1) * sym_cycles) / 8;
    endfunction

endpackage

// File: rtl/ask_line_sync.sv
// rtl/ask_line_sync.sv - 2-FF synchronizer, optional majority filter (ASK_DEMOD_GLITCH_FILTER_EN), rising-edge detector.
module ask_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic line_async,
    output logic level,
    output logic rise
);

    logic sync0;
    logic sync1;
    logic level_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
        end else begin
            sync0 <= line_async;
            sync1 <= sync0;
        end
    end

`ifdef ASK_DEMOD_GLITCH_FILTER_EN
    logic hist0;
    logic hist1;
    logic filt;

    // Registered majority of three consecutive samples: two cycles of delay, single-cycle pulses vanish.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist0 <= 1'b0;
            hist1 <= 1'b0;
            filt  <= 1'b0;
        end else begin
            hist0 <= sync1;
            hist1 <= hist0;
            filt  <= (sync1 & hist0) | (sync1 & hist1) | (hist0 & hist1);
        end
    end

    assign level = filt;
`else
    assign level = sync1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_d <= 1'b0;
        end else begin
            level_d <= level;
        end
    end

    assign rise = level & ~level_d;

endmodule

// File: rtl/ask4_pwm_demod.sv
// rtl/ask4_pwm_demod.sv - 4-ASK PWM line demodulator; ASK_DEMOD_GLITCH_FILTER_EN enables the input majority filter.
module ask4_pwm_demod
    import ask_pkg::*;
#(
    parameter int SYM_CYCLES = SYM_CYCLES_DEFAULT,
    parameter int TOL_CYCLES = TOL_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       _4ASK,
    output logic [1:0] sym,
    output logic       sym_valid,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       sync_err
);

    localparam int CW = $clog2(SYM_CYCLES + 1);
    typedef logic [CW-1:0] cnt_t;
    typedef logic [CW+1:0] cmp_t;

    localparam cnt_t CNT_LAST  = cnt_t'(SYM_CYCLES - 1);
    localparam cnt_t CNT_EARLY = cnt_t'(SYM_CYCLES - TOL_CYCLES);
    localparam cnt_t GAP_LAST  = cnt_t'(TOL_CYCLES - 1);
    localparam cnt_t CNT_MAX   = '1;
    localparam cnt_t CNT_ONE   = cnt_t'(1);
    localparam cmp_t TH1       = cmp_t'(SYM_CYCLES);
    localparam cmp_t TH2       = cmp_t'(2 * SYM_CYCLES);
    localparam cmp_t TH3       = cmp_t'(3 * SYM_CYCLES);

    logic       level;
    logic       rise;
    state_t     state;
    cnt_t       cnt;
    cnt_t       hi_cnt;
    cnt_t       cnt_inc;
    cnt_t       hi_inc;
    cmp_t       hi4;
    logic [1:0] q;
    logic [1:0] sym_idx;
    logic [5:0] acc;
    logic       fin;

    ask_line_sync u_line_sync (
        .clk        (clk),
        .rst        (rst),
        .line_async (_4ASK),
        .level      (level),
        .rise       (rise)
    );

    // Duty quantization by comparing 4*hi_cnt against multiples of the period, avoiding a divider.
    always_comb begin
        cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
        hi_inc  = (level && hi_cnt != CNT_MAX) ? hi_cnt + CNT_ONE : hi_cnt;
        hi4     = {hi_cnt, 2'b00};
        if (hi4 < TH1) begin
            q = 2'd0;
        end else if (hi4 < TH2) begin
            q = 2'd1;
        end else if (hi4 < TH3) begin
            q = 2'd2;
        end else begin
            q = 2'd3;
        end
        fin = (state == ST_MEASURE) &&
              ((rise && cnt >= CNT_EARLY) || (!rise && cnt == CNT_LAST));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            hi_cnt     <= '0;
            sym_idx    <= 2'd0;
            acc        <= 6'd0;
            sym        <= 2'd0;
            sym_valid  <= 1'b0;
            data       <= 8'd0;
            data_valid <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            sym_valid  <= 1'b0;
            data_valid <= 1'b0;
            sync_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        state   <= ST_MEASURE;
                        cnt     <= '0;
                        hi_cnt  <= '0;
                        sym_idx <= 2'd0;
                    end
                end
                ST_MEASURE: begin
                    if (rise) begin
                        cnt    <= '0;
                        hi_cnt <= '0;
                        if (cnt < CNT_EARLY) begin
                            sync_err <= 1'b1;
                            sym_idx  <= 2'd0;
                            state    <= ST_IDLE;
                        end
                    end else if (cnt == CNT_LAST) begin
                        cnt    <= '0;
                        hi_cnt <= '0;
                        state  <= ST_GAP;
                    end else begin
                        cnt    <= cnt_inc;
                        hi_cnt <= hi_inc;
                    end
                end
                ST_GAP: begin
                    if (rise) begin
                        state  <= ST_MEASURE;
                        cnt    <= '0;
                        hi_cnt <= '0;
                    end else if (cnt == GAP_LAST) begin
                        state   <= ST_IDLE;
                        cnt     <= '0;
                        sym_idx <= 2'd0;
                        if (sym_idx != 2'd0) begin
                            sync_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    cnt     <= '0;
                    hi_cnt  <= '0;
                    sym_idx <= 2'd0;
                end
            endcase

            // Symbols fill the byte MSB-first; the fourth one completes it.
            if (fin) begin
                sym       <= q;
                sym_valid <= 1'b1;
                if (sym_idx == 2'd3) begin
                    data       <= {acc, q};
                    data_valid <= 1'b1;
                    sym_idx    <= 2'd0;
                end else begin
                    acc     <= {acc[3:0], q};
                    sym_idx <= sym_idx + 2'd1;
                end
            end
        end
    end

endmodule

// File: doc/ask4_pwm_demod.md
ASK4_PWM_DEMOD -- requirements
Module: ask4_pwm_demod

Interface
REQ-001 Parameter SYM_CYCLES, 62500, clk cycles per symbol (800 Hz symbol rate at 50 MHz).
REQ-002 Parameter TOL_CYCLES, 625, allowed symbol-boundary jitter in clk cycles; SHALL be < SYM_CYCLES/8.
REQ-003 Port clk, input, 1, single system clock; all logic in this domain.
REQ-004 Port rst, input, 1, reset: asynchronous, active-high.
REQ-005 Port _4ASK, input, 1, 4-ASK PWM line from the modulator; asynchronous to clk.
REQ-006 Port sym, output, 2, last decoded symbol.
REQ-007 Port sym_valid, output, 1, one-cycle strobe qualifying sym.
REQ-008 Port data, output, 8, last assembled byte.
REQ-009 Port data_valid, output, 1, one-cycle strobe qualifying data.
REQ-010 Port sync_err, output, 1, one-cycle strobe on framing loss.

Function
REQ-011 Line format: each symbol starts with a rising edge; high time = (2n+1)/8 of SYM_CYCLES for symbol n in 0..3; line idles low between bytes.
REQ-012 _4ASK SHALL pass a 2-FF synchronizer and then a rising-edge detector; decode latency counts from the detector output.
REQ-013 FSM states: IDLE, MEASURE, GAP.
REQ-014 IDLE: rising edge -> MEASURE, cnt=0, hi_cnt=0, sym_idx=0.
REQ-015 MEASURE: cnt increments each cycle; hi_cnt increments while the synchronized line is high; both saturate, with width ceil(log2(SYM_CYCLES+1)).
REQ-016 MEASURE at cnt==SYM_CYCLES-1 -> GAP, finalize symbol.
REQ-017 A rising edge in MEASURE with cnt >= SYM_CYCLES-TOL_CYCLES finalizes the symbol early and restarts MEASURE at cnt=0 for the next symbol.
REQ-018 A rising edge in MEASURE with cnt < SYM_CYCLES-TOL_CYCLES: glitch -> sync_err pulse, partial byte discarded, -> IDLE.
REQ-019 GAP: rising edge within TOL_CYCLES -> MEASURE for the next symbol; timeout with sym_idx==0 -> IDLE silently; timeout with sym_idx!=0 -> sync_err, discard partial byte, -> IDLE.
REQ-020 Quantization without division: compare 4*hi_cnt against SYM_CYCLES, 2*SYM_CYCLES, 3*SYM_CYCLES; below first -> 00, below second -> 01, below third -> 10, else 11; comparison width = counter width + 2.
REQ-021 Finalizing a symbol SHALL drive sym and a sym_valid pulse on the next clk edge.
REQ-022 Symbols assemble MSB-first: sym_idx 0 -> data[7:6] ... sym_idx 3 -> data[1:0].
REQ-023 The 4th symbol SHALL pulse data_valid in the same cycle as its sym_valid; sym_idx wraps to 0.
REQ-024 data and sym hold their value until the next valid; no backpressure.

Reset
REQ-025 rst asserted: state=IDLE, counters=0, sym_idx=0, synchronizer=0; sym=0, data=0, all strobes 0.
REQ-026 rst asserted mid-byte discards the partial byte with no sync_err; the first rising edge after release starts a new byte.

Configuration
REQ-027 With ASK_DEMOD_GLITCH_FILTER_EN defined, a 3-sample majority filter SHALL follow the synchronizer, adding 2 cycles of latency; pulses of 1 clk or shorter SHALL be rejected.
REQ-028 Without ASK_DEMOD_GLITCH_FILTER_EN, the synchronizer output SHALL feed the edge detector directly.

Structure
REQ-029 Package ask_pkg SHALL hold the state enum, the SYM_CYCLES/TOL_CYCLES defaults, and the symbol-to-duty table shared with the modulator.
REQ-030 Sub-module ask_line_sync SHALL contain the synchronizer, optional majority filter, and edge detector.

Verification
REQ-031 Byte 8'b11100100 sent at nominal timing -> sym sequence 3,2,1,0, then data_valid with data=8'hE4, sync_err never asserted.
REQ-032 Byte 8'h1B with every symbol boundary shifted +600 cycles -> data=8'h1B, no sync_err.
REQ-033 Line held low after the 2nd symbol -> sync_err pulse after TOL_CYCLES of GAP, no data_valid, FSM returns to IDLE.
REQ-034 Extra rising edge at cnt=10000 during symbol 1 -> sync_err, then a clean following byte 8'hA5 decodes correctly.
REQ-035 rst pulse during symbol 2 -> all outputs 0 immediately (asynchronous); the next byte 8'h3C decodes correctly.
REQ-036 Run with ASK_DEMOD_GLITCH_FILTER_EN defined: a 1-cycle high glitch mid-symbol -> no sync_err, correct byte.
